microc_param: RTL and testbench

MICROC_PARAM -- requirements
Module: microc_param

---
 rtl/microc_param.sv | 166 ++++++++++++++++
 tb/tb_microc_param.sv | 322 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/microc_param.sv
// Parameterised 16-bit-instruction microcontroller: 16 x DW register file,
// return stack, and a FETCH/EXEC/WB/HALT sequencer gated by run.
module microc_param #(
  parameter int DW     = 8,
  parameter int PCW    = 10,
  parameter int SDEPTH = 4
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           run,
  output logic [PCW-1:0] imem_addr,
  input  logic [15:0]    imem_data,
  input  logic [3:0]     dbg_addr,
  output logic [DW-1:0]  dbg_data,
  output logic           z,
  output logic [1:0]     state,
  output logic           stack_err
);

  typedef enum logic [1:0] {
    S_FETCH = 2'b00,
    S_EXEC  = 2'b01,
    S_WB    = 2'b10,
    S_HALT  = 2'b11
  } state_t;

  localparam int AW  = $clog2(SDEPTH);
  localparam int SPW = AW + 1;

  localparam logic [5:0] OPC_J    = 6'b100100;
  localparam logic [5:0] OPC_JZ   = 6'b100101;
  localparam logic [5:0] OPC_JNZ  = 6'b100110;
  localparam logic [5:0] OPC_CALL = 6'b100111;
  localparam logic [5:0] OPC_RET  = 6'b101000;
  localparam logic [5:0] OPC_HALT = 6'b111111;

  state_t           r_state, w_next_state;
  logic [PCW-1:0]   r_pc;
  logic [15:0]      r_ir;
  logic [DW-1:0]    r_aluout;
  logic             r_z;
  logic [SPW-1:0]   r_sp;
  logic             r_stack_err;
  logic [DW-1:0]    r_rf    [16];
  logic [PCW-1:0]   r_stack [SDEPTH];

  logic             w_is_alu, w_is_li, w_stack_full, w_stack_empty, w_do_push;
  logic [5:0]       w_opc;
  logic [PCW-1:0]   w_target, w_ret_pc;
  logic [SPW-1:0]   w_sp_dec;
  logic [DW-1:0]    w_a, w_b, w_alu;

  assign w_is_alu      = ~r_ir[15];
  assign w_is_li       = (r_ir[15:12] == 4'b1000);
  assign w_opc         = r_ir[15:10];
  assign w_target      = r_ir[PCW-1:0];
  assign w_a           = r_rf[r_ir[11:8]];
  assign w_b           = r_rf[r_ir[7:4]];
  assign w_stack_full  = (r_sp == SPW'(SDEPTH));
  assign w_stack_empty = (r_sp == '0);
  assign w_sp_dec      = r_sp - SPW'(1);
  assign w_ret_pc      = r_stack[w_sp_dec[AW-1:0]];
  assign w_do_push     = (r_state == S_EXEC) && (w_opc == OPC_CALL) && !w_stack_full;

  always_comb begin
    w_alu = w_a;
    case (r_ir[14:12])
      3'b000:  w_alu = w_a;
      3'b001:  w_alu = ~w_a;
      3'b010:  w_alu = w_a + w_b;
      3'b011:  w_alu = w_a - w_b;
      3'b100:  w_alu = w_a & w_b;
      3'b101:  w_alu = w_a | w_b;
      3'b110:  w_alu = -w_a;
      default: w_alu = -w_b;
    endcase
  end

  // NOTE: every output of a combinational block gets a default on entry so no
  // path through the case leaves it unassigned and a latch is never inferred.
  always_comb begin
    w_next_state = r_state;
    if (run) begin
      case (r_state)
        S_FETCH: w_next_state = S_EXEC;
        S_EXEC: begin
          if (w_is_alu || w_is_li)                             w_next_state = S_WB;
          else if (w_opc == OPC_HALT)                          w_next_state = S_HALT;
          else if ((w_opc == OPC_CALL) && w_stack_full)        w_next_state = S_HALT;
          else if ((w_opc == OPC_RET)  && w_stack_empty)       w_next_state = S_HALT;
          else                                                 w_next_state = S_FETCH;
        end
        S_WB:    w_next_state = S_FETCH;
        default: w_next_state = S_HALT;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_state <= S_FETCH;
    else        r_state <= w_next_state;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_pc        <= '0;
      r_ir        <= '0;
      r_aluout    <= '0;
      r_z         <= 1'b0;
      r_sp        <= '0;
      r_stack_err <= 1'b0;
      for (int i = 0; i < 16; i++) r_rf[i] <= '0;
    end else if (run) begin
      case (r_state)
        S_FETCH: begin
          r_ir <= imem_data;
          r_pc <= r_pc + PCW'(1);
        end
        S_EXEC: begin
          if (w_is_alu) begin
            r_aluout <= w_alu;
            r_z      <= (w_alu == '0);
          end else if (w_is_li) begin
            r_aluout <= DW'(r_ir[11:4]);
          end else begin
            case (w_opc)
              OPC_J:   r_pc <= w_target;
              OPC_JZ:  if (r_z)  r_pc <= w_target;
              OPC_JNZ: if (!r_z) r_pc <= w_target;
              OPC_CALL: begin
                if (w_stack_full) r_stack_err <= 1'b1;
                else begin
                  r_sp <= r_sp + SPW'(1);
                  r_pc <= w_target;
                end
              end
              OPC_RET: begin
                if (w_stack_empty) r_stack_err <= 1'b1;
                else begin
                  r_sp <= w_sp_dec;
                  r_pc <= w_ret_pc;
                end
              end
              default: ;
            endcase
          end
        end
        S_WB: if (r_ir[3:0] != 4'd0) r_rf[r_ir[3:0]] <= r_aluout;
        default: ;
      endcase
    end
  end

  // NOTE: stack entries carry no reset; SP alone decides which entries are
  // live, so clearing the storage would buy nothing.
  always_ff @(posedge clk) begin
    if (run && w_do_push) r_stack[r_sp[AW-1:0]] <= r_pc;
  end

  assign imem_addr = r_pc;
  assign dbg_data  = (dbg_addr == 4'd0) ? '0 : r_rf[dbg_addr];
  assign z         = r_z;
  assign state     = r_state;
  assign stack_err = r_stack_err;

endmodule

// File: tb/tb_microc_param.sv
// Self-checking bench for microc_param: ALU vector table, hand sequences for
// control-flow/stack/freeze/reset corners, and random programs vs an ISA model.
module tb_microc_param;

  localparam int DW = 8;
  localparam int PCW = 10;
  localparam logic [15:0] NOP_W = 16'hA400;

  logic           clk, reset, run;
  logic [PCW-1:0] imem_addr;
  logic [15:0]    imem_data;
  logic [3:0]     dbg_addr;
  logic [DW-1:0]  dbg_data;
  logic           z, stack_err;
  logic [1:0]     state;

  logic [15:0] rom [1024];
  assign imem_data = rom[imem_addr];

  microc_param #(.DW(DW), .PCW(PCW), .SDEPTH(4)) dut (
    .clk(clk), .reset(reset), .run(run),
    .imem_addr(imem_addr), .imem_data(imem_data),
    .dbg_addr(dbg_addr), .dbg_data(dbg_data),
    .z(z), .state(state), .stack_err(stack_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [15:0] alu(input int op, input int ra, input int rb, input int rd);
    return {1'b0, 3'(op), 4'(ra), 4'(rb), 4'(rd)};
  endfunction
  function automatic logic [15:0] li(input int rd, input int imm);
    return {4'b1000, 8'(imm), 4'(rd)};
  endfunction
  function automatic logic [15:0] ctl(input logic [5:0] opc, input int t);
    return {opc, 10'(t)};
  endfunction

  localparam logic [5:0] J = 6'b100100, JZ = 6'b100101, JNZ = 6'b100110;
  localparam logic [5:0] CALL = 6'b100111, RET = 6'b101000, HALT = 6'b111111;

  task automatic tick(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic clear_rom();
    for (int i = 0; i < 1024; i++) rom[i] = NOP_W;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    run   = 1'b1;
    tick(2);
    reset = 1'b1;
  endtask

  function automatic logic [DW-1:0] rd_reg(input int r);
    dbg_addr = 4'(r);
    return dbg_data;
  endfunction

  task automatic check_reg(input string name, input int r, input logic [DW-1:0] exp);
    dbg_addr = 4'(r);
    #1;
    check(name, 32'(dbg_data), 32'(exp));
  endtask

  // Instruction-level reference model.
  logic [DW-1:0]  m_regs [16];
  logic           m_z;
  logic [PCW-1:0] m_pc;

  task automatic model_reset();
    for (int i = 0; i < 16; i++) m_regs[i] = '0;
    m_z  = 1'b0;
    m_pc = '0;
  endtask

  task automatic model_step(output int cyc);
    logic [15:0] ins;
    logic [DW-1:0] a, b, r;
    ins  = rom[m_pc];
    m_pc = m_pc + 1'b1;
    if (!ins[15]) begin
      a = m_regs[ins[11:8]];
      b = m_regs[ins[7:4]];
      case (ins[14:12])
        3'd0: r = a;
        3'd1: r = ~a;
        3'd2: r = a + b;
        3'd3: r = a - b;
        3'd4: r = a & b;
        3'd5: r = a | b;
        3'd6: r = 0 - a;
        default: r = 0 - b;
      endcase
      m_z = (r == 0);
      if (ins[3:0] != 0) m_regs[ins[3:0]] = r;
      cyc = 3;
    end else if (ins[15:12] == 4'b1000) begin
      if (ins[3:0] != 0) m_regs[ins[3:0]] = DW'(ins[11:4]);
      cyc = 3;
    end else begin
      cyc = 2;
      if (ins[15:10] == J) m_pc = ins[PCW-1:0];
      else if (ins[15:10] == JZ  &&  m_z) m_pc = ins[PCW-1:0];
      else if (ins[15:10] == JNZ && !m_z) m_pc = ins[PCW-1:0];
    end
  endtask

  typedef struct {
    string      name;
    logic [2:0] op;
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] exp_r;
    logic       exp_z;
  } alu_vec_t;

  alu_vec_t vecs [10];

  initial begin
    vecs[0] = '{"mov",     3'd0, 8'h5A, 8'h00, 8'h5A, 1'b0};
    vecs[1] = '{"not",     3'd1, 8'h0F, 8'h00, 8'hF0, 1'b0};
    vecs[2] = '{"not_ff",  3'd1, 8'hFF, 8'h00, 8'h00, 1'b1};
    vecs[3] = '{"add_wrap",3'd2, 8'hFF, 8'h01, 8'h00, 1'b1};
    vecs[4] = '{"sub_eq",  3'd3, 8'h05, 8'h05, 8'h00, 1'b1};
    vecs[5] = '{"sub_neg", 3'd3, 8'h03, 8'h05, 8'hFE, 1'b0};
    vecs[6] = '{"and",     3'd4, 8'hCC, 8'hAA, 8'h88, 1'b0};
    vecs[7] = '{"or",      3'd5, 8'hCC, 8'hAA, 8'hEE, 1'b0};
    vecs[8] = '{"neg_a",   3'd6, 8'h01, 8'h00, 8'hFF, 1'b0};
    vecs[9] = '{"neg_b",   3'd7, 8'h00, 8'h80, 8'h80, 1'b0};

    reset = 1'b0; run = 1'b1; dbg_addr = '0;
    clear_rom();

    // Reset state
    do_reset();
    check("rst_pc", 32'(imem_addr), 0);
    check("rst_state", 32'(state), 0);
    check("rst_z", 32'(z), 0);
    check("rst_err", 32'(stack_err), 0);
    check_reg("rst_r7", 7, 0);

    // ALU vector table
    foreach (vecs[i]) begin
      clear_rom();
      rom[0] = li(1, vecs[i].a);
      rom[1] = li(2, vecs[i].b);
      rom[2] = alu(vecs[i].op, 1, 2, 3);
      do_reset();
      tick(9);
      check_reg({"alu_", vecs[i].name}, 3, vecs[i].exp_r);
      check({"z_", vecs[i].name}, 32'(z), 32'(vecs[i].exp_z));
    end

    // LI/LI/SUB/JZ with cycle-by-cycle state trace
    begin
      logic [1:0] exp_st [11];
      exp_st = '{2'b01, 2'b10, 2'b00, 2'b01, 2'b10, 2'b00, 2'b01, 2'b10, 2'b00, 2'b01, 2'b00};
      clear_rom();
      rom[0] = li(1, 5); rom[1] = li(2, 5); rom[2] = alu(3, 1, 2, 3); rom[3] = ctl(JZ, 'h3F);
      do_reset();
      for (int c = 0; c < 11; c++) begin
        tick(1);
        check($sformatf("trace_state_c%0d", c + 1), 32'(state), 32'(exp_st[c]));
      end
      check("trace_pc", 32'(imem_addr), 'h3F);
      check("trace_z", 32'(z), 1);
      check_reg("trace_r3", 3, 0);
    end

    // LI zero-extension and R0 write ignored
    clear_rom();
    rom[0] = li(0, 'h33); rom[1] = li(9, 'h80);
    do_reset();
    tick(6);
    check_reg("r0_ignored", 0, 0);
    check_reg("li_r9", 9, 'h80);

    // CALL/RET and return address
    clear_rom();
    rom[0] = ctl(J, 5); rom[5] = ctl(CALL, 'h20); rom['h20] = ctl(RET, 0); rom[6] = ctl(RET, 0);
    do_reset();
    tick(2); check("cr_pc_j", 32'(imem_addr), 'h05);
    tick(2); check("cr_pc_call", 32'(imem_addr), 'h20);
    tick(2); check("cr_pc_ret", 32'(imem_addr), 'h06);
    check("cr_err_clean", 32'(stack_err), 0);
    tick(2);
    check("cr_underflow_err", 32'(stack_err), 1);
    check("cr_underflow_state", 32'(state), 3);
    check("cr_underflow_pc", 32'(imem_addr), 'h07);

    // Five nested CALLs overflow a 4-deep stack
    clear_rom();
    for (int k = 0; k < 5; k++) rom[k * 'h10] = ctl(CALL, (k + 1) * 'h10);
    do_reset();
    tick(8);
    check("ovf_pc4", 32'(imem_addr), 'h40);
    check("ovf_err_before", 32'(stack_err), 0);
    tick(2);
    check("ovf_err", 32'(stack_err), 1);
    check("ovf_state", 32'(state), 3);
    check("ovf_pc", 32'(imem_addr), 'h41);
    tick(5);
    check("ovf_halt_stays", 32'(state), 3);
    check("ovf_pc_stays", 32'(imem_addr), 'h41);

    // RET straight after reset
    clear_rom();
    rom[0] = ctl(RET, 0);
    do_reset();
    tick(2);
    check("ret0_err", 32'(stack_err), 1);
    check("ret0_state", 32'(state), 3);
    check("ret0_pc", 32'(imem_addr), 1);

    // run=0 for 7 cycles during WB of ADD
    clear_rom();
    rom[0] = li(1, 3); rom[1] = li(2, 4); rom[2] = alu(2, 1, 2, 4); rom[3] = ctl(HALT, 0);
    do_reset();
    tick(8);
    check("frz_state_wb", 32'(state), 2);
    run = 1'b0;
    for (int c = 0; c < 7; c++) begin
      tick(1);
      check($sformatf("frz_state_%0d", c), 32'(state), 2);
      check($sformatf("frz_pc_%0d", c), 32'(imem_addr), 3);
      check_reg($sformatf("frz_r4_%0d", c), 4, 0);
    end
    run = 1'b1;
    tick(1);
    check_reg("frz_r4_done", 4, 7);
    check("frz_state_fetch", 32'(state), 0);
    tick(2);
    check("halt_state", 32'(state), 3);
    tick(3);
    check("halt_pc", 32'(imem_addr), 4);

    // PC wrap from 2^PCW-1
    clear_rom();
    rom[0] = ctl(J, 'h3FF); rom['h3FF] = NOP_W;
    do_reset();
    tick(2); check("wrap_pc_top", 32'(imem_addr), 'h3FF);
    tick(2); check("wrap_pc_zero", 32'(imem_addr), 0);
    check("wrap_state", 32'(state), 0);

    // Reset asserted during WB of LI R5,0x7A
    clear_rom();
    rom[0] = li(5, 'h7A); rom[1] = li(5, 'h11);
    do_reset();
    tick(3);
    check_reg("rstwb_r5_loaded", 5, 'h7A);
    tick(2);
    check("rstwb_in_wb", 32'(state), 2);
    reset = 1'b0;
    #1;
    check_reg("rstwb_r5_cleared", 5, 0);
    check("rstwb_pc", 32'(imem_addr), 0);
    check("rstwb_state", 32'(state), 0);
    tick(1);
    check_reg("rstwb_r5_held", 5, 0);
    reset = 1'b1;
    tick(1);
    check("rstwb_after_fetch", 32'(state), 1);
    check("rstwb_after_pc", 32'(imem_addr), 1);

    // Random programs with random run stalls, against the ISA model
    for (int p = 0; p < 4; p++) begin
      clear_rom();
      for (int a = 0; a < 32; a++) begin
        int kind;
        kind = $urandom_range(0, 9);
        if (kind <= 4)
          rom[a] = alu($urandom_range(0, 7), $urandom_range(0, 15), $urandom_range(0, 15), $urandom_range(0, 15));
        else if (kind <= 7)
          rom[a] = li($urandom_range(0, 15), $urandom_range(0, 255));
        else if (kind == 8) begin
          logic [5:0] bops [3];
          bops = '{J, JZ, JNZ};
          rom[a] = ctl(bops[$urandom_range(0, 2)], $urandom_range(0, 31));
        end else
          rom[a] = NOP_W;
      end
      model_reset();
      do_reset();
      for (int s = 0; s < 50; s++) begin
        int cyc, split;
        model_step(cyc);
        split = $urandom_range(0, cyc);
        tick(split);
        if ($urandom_range(0, 3) == 0) begin
          run = 1'b0;
          tick($urandom_range(1, 4));
          run = 1'b1;
        end
        tick(cyc - split);
        check($sformatf("rnd%0d_s%0d_pc", p, s), 32'(imem_addr), 32'(m_pc));
        check($sformatf("rnd%0d_s%0d_z", p, s), 32'(z), 32'(m_z));
        check($sformatf("rnd%0d_s%0d_state", p, s), 32'(state), 0);
      end
      for (int r = 0; r < 16; r++)
        check_reg($sformatf("rnd%0d_r%0d", p, r), r, m_regs[r]);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
